// File: rtl/strip_pool_pkg.sv
// Shared definitions for the strip ReLU/max-pool stage: default geometry,
// derived pooled-map size and the FSM state encoding.
package strip_pool_pkg;

  localparam int DEF_IN_W   = 222;
  localparam int DEF_IN_H   = 28;
  localparam int DEF_DW     = 9;
  localparam int DEF_AW     = 16;
  localparam int DEF_RD_LAT = 2;

  localparam int DEF_OUT_W  = DEF_IN_W / 2;
  localparam int DEF_OUT_H  = DEF_IN_H / 2;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_ISSUE = 3'd1,
    ST_DRAIN = 3'd2,
    ST_WRITE = 3'd3,
    ST_DONE  = 3'd4
  } state_t;

endpackage

// File: rtl/pool_max_tracker.sv
// Running signed maximum over one 2x2 pooling window.
// With POOL_RELU_EN defined, negative samples are clamped to 0 before the compare.
module pool_max_tracker
  import strip_pool_pkg::*;
#(
  parameter int DW = DEF_DW
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic signed [DW-1:0] sample_i,
  input  logic                 valid_i,
  input  logic                 first_i,
  output logic signed [DW-1:0] max_d_o
);

  logic signed [DW-1:0] sample_c;
  logic signed [DW-1:0] max_q;
  logic signed [DW-1:0] max_d;

`ifdef POOL_RELU_EN
  assign sample_c = sample_i[DW-1] ? '0 : sample_i;
`else
  assign sample_c = sample_i;
`endif

  // The first return of a window overwrites whatever the previous window left.
  always_comb begin
    max_d = max_q;
    if (valid_i && (first_i || (sample_c > max_q))) begin
      max_d = sample_c;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      max_q <= '0;
    end else begin
      max_q <= max_d;
    end
  end

  // The top registers the value being formed this cycle so the write carries the last sample.
  assign max_d_o = max_d;

endmodule

// File: rtl/strip_relu_maxpool.sv
// Reads a finished strip convolution BRAM, applies optional ReLU (POOL_RELU_EN)
// and 2x2 stride-2 max pooling, and writes one pooled value per window.
module strip_relu_maxpool
  import strip_pool_pkg::*;
#(
  parameter int IN_W   = DEF_IN_W,
  parameter int IN_H   = DEF_IN_H,
  parameter int DW     = DEF_DW,
  parameter int AW     = DEF_AW,
  parameter int RD_LAT = DEF_RD_LAT
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 start,
  input  logic                 conv_done,
  output logic [AW-1:0]        rd_addr,
  output logic                 rd_en,
  input  logic signed [DW-1:0] rd_data,
  output logic                 wr_en,
  output logic [AW-1:0]        wr_addr,
  output logic signed [DW-1:0] wr_data,
  output logic                 busy,
  output logic                 done,
  output logic [2:0]           dbg_state
);

  localparam int OUT_W = IN_W / 2;
  localparam int OUT_H = IN_H / 2;
  localparam logic [AW-1:0] ROW_OFS    = AW'(IN_W);
  localparam logic [AW-1:0] ROW_STEP   = AW'(2 * IN_W);
  localparam logic [AW-1:0] LAST_C     = AW'(OUT_W - 1);
  localparam logic [AW-1:0] LAST_R     = AW'(OUT_H - 1);
  localparam logic [7:0]    DRAIN_LAST = 8'(RD_LAT - 1);

  state_t                state_q;
  logic [7:0]            cnt_q;
  logic [AW-1:0]         c_q, r_q;
  logic [AW-1:0]         base_q, row_base_q, wr_idx_q;
  logic [AW-1:0]         rd_addr_q, wr_addr_q;
  logic                  rd_en_q, wr_en_q, busy_q, done_q;
  logic signed [DW-1:0]  wr_data_q;
  logic [RD_LAT-1:0]     vld_q, vld_d, fst_q, fst_d;
  logic signed [DW-1:0]  trk_max_d;

  // Each issued read is tagged so its return lines up with rd_data RD_LAT cycles later.
  always_comb begin
    vld_d    = vld_q << 1;
    fst_d    = fst_q << 1;
    vld_d[0] = rd_en_q;
    fst_d[0] = (state_q == ST_ISSUE) && (cnt_q == 8'd0);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      vld_q <= '0;
      fst_q <= '0;
    end else begin
      vld_q <= vld_d;
      fst_q <= fst_d;
    end
  end

  pool_max_tracker #(.DW(DW)) u_tracker (
    .clk      (clk),
    .reset    (reset),
    .sample_i (rd_data),
    .valid_i  (vld_q[RD_LAT-1]),
    .first_i  (fst_q[RD_LAT-1]),
    .max_d_o  (trk_max_d)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= ST_IDLE;
      cnt_q      <= '0;
      c_q        <= '0;
      r_q        <= '0;
      base_q     <= '0;
      row_base_q <= '0;
      wr_idx_q   <= '0;
      rd_addr_q  <= '0;
      rd_en_q    <= 1'b0;
      wr_en_q    <= 1'b0;
      wr_addr_q  <= '0;
      wr_data_q  <= '0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      wr_en_q <= 1'b0;
      case (state_q)
        ST_IDLE, ST_DONE: begin
          if (start && conv_done) begin
            state_q    <= ST_ISSUE;
            cnt_q      <= '0;
            c_q        <= '0;
            r_q        <= '0;
            base_q     <= '0;
            row_base_q <= '0;
            wr_idx_q   <= '0;
            rd_addr_q  <= '0;
            rd_en_q    <= 1'b1;
            busy_q     <= 1'b1;
            done_q     <= 1'b0;
          end
        end
        ST_ISSUE: begin
          cnt_q <= cnt_q + 8'd1;
          case (cnt_q[1:0])
            2'd0: rd_addr_q <= base_q + AW'(1);
            2'd1: rd_addr_q <= base_q + ROW_OFS;
            2'd2: rd_addr_q <= base_q + ROW_OFS + AW'(1);
            default: begin
              rd_en_q <= 1'b0;
              cnt_q   <= '0;
              state_q <= ST_DRAIN;
            end
          endcase
        end
        ST_DRAIN: begin
          if (cnt_q == DRAIN_LAST) begin
            state_q   <= ST_WRITE;
            wr_en_q   <= 1'b1;
            wr_addr_q <= wr_idx_q;
            wr_data_q <= trk_max_d;
          end else begin
            cnt_q <= cnt_q + 8'd1;
          end
        end
        ST_WRITE: begin
          wr_idx_q <= wr_idx_q + AW'(1);
          cnt_q    <= '0;
          if (c_q == LAST_C) begin
            c_q <= '0;
            r_q <= r_q + AW'(1);
            if (r_q == LAST_R) begin
              state_q <= ST_DONE;
              busy_q  <= 1'b0;
              done_q  <= 1'b1;
            end else begin
              state_q    <= ST_ISSUE;
              row_base_q <= row_base_q + ROW_STEP;
              base_q     <= row_base_q + ROW_STEP;
              rd_addr_q  <= row_base_q + ROW_STEP;
              rd_en_q    <= 1'b1;
            end
          end else begin
            state_q   <= ST_ISSUE;
            c_q       <= c_q + AW'(1);
            base_q    <= base_q + AW'(2);
            rd_addr_q <= base_q + AW'(2);
            rd_en_q   <= 1'b1;
          end
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign rd_addr   = rd_addr_q;
  assign rd_en     = rd_en_q;
  assign wr_en     = wr_en_q;
  assign wr_addr   = wr_addr_q;
  assign wr_data   = wr_data_q;
  assign busy      = busy_q;
  assign done      = done_q;
  assign dbg_state = state_q;

endmodule
